mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and select controller for the team's 8:1 single-bit mux.
- Shares the mux between 8 requesters and drives its 3-bit select from the current owner.
- Emits a one-hot grant and a valid flag.
- Bounds each ownership to MAX_HOLD cycles so no requester starves the others.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant; legal range 1..255; 0 is illegal.
- HOLD_W, 8, width of the internal hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
- req  input  8  request vector; req[i] high means requester i wants mux input I[i] routed to Out.
- grant  output  8  one-hot grant, registered.
- sel  output  3  binary index of the owner; drives mux S[2:0]; registered.
- valid  output  1  high when grant is non-zero (mux output meaningful).
- owner_done  output  1  single-cycle pulse in the cycle a grant is released.

Behaviour:
- Reset (async, rst_n=0): grant=0, sel=0, valid=0, owner_done=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- State machine:
  - IDLE: if |req, pick the winner and go to GRANT; else stay IDLE with grant=0.
  - GRANT: owner fixed; hold_cnt increments each cycle.
- Winner selection: the first i with req[i]=1, scanning cyclically rr_ptr, rr_ptr+1, ..., rr_ptr+7 (mod 8).
- Latency: req sampled at edge N gives grant/sel/valid at edge N+1.
- Release condition, evaluated in GRANT each cycle:
  - req[owner]=0, or
  - hold_cnt == MAX_HOLD-1, meaning the grant has been held for MAX_HOLD cycles.
- On release:
  - owner_done=1 for that cycle.
  - rr_ptr <= owner+1, wrapping 7 -> 0.
  - Next winner is computed from the updated pointer and the current req.
  - If a winner exists, the new grant appears at the next edge (back-to-back, no idle cycle), and hold_cnt resets to 0.
  - If no winner exists, go to IDLE with grant=0 and valid=0.
- Sole requester: if the releasing owner is the only requester, it re-wins immediately at the next edge with a fresh hold window.
- Requests from non-owners during GRANT do not preempt; they wait for release.
- sel always equals the binary encoding of grant. When grant=0, sel holds 0.
- Simultaneous events: requests arriving in the release cycle participate in selection for that cycle.
- Reset mid-grant: outputs clear asynchronously and the pointer returns to 0.
- MAX_HOLD=1: every grant lasts exactly one cycle and ownership rotates each cycle among active requesters.

Optional Feature:
- Macro: MUX8_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1 in GRANT, the MAX_HOLD release is suppressed and hold_cnt saturates at MAX_HOLD-1.
  - Release then happens only when req[owner] drops.
  - lock is ignored in IDLE.
- Undefined: no lock port; the MAX_HOLD limit always applies.

Decomposition:
- Shared package mux8_arb_pkg contains:
  - NUM_REQ=8 and SEL_W=3 constants.
  - State enum {IDLE, GRANT}.
  - Function onehot_to_bin(8-bit) returning 3 bits.
- Sub-module rr_pick8 (combinational): inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0].
- Arbiter top instantiates rr_pick8 once. The team's existing 8:1 mux is instantiated by the integrating level, not inside this block.

Test Plan:
- Reset: rst_n=0 with req=8'hFF -> grant=0, sel=0, valid=0; after release, first edge gives grant=8'h01, sel=0.
- Rotation: req=8'hFF held, MAX_HOLD=4 -> owners 0,1,2,...,7,0, each exactly 4 cycles, owner_done pulses every 4th cycle, no idle cycles.
- Early release: req=8'h24, owner 2 drops req after 2 cycles -> owner_done pulses, grant=8'h20/sel=5 on the next edge.
- Sole requester: req=8'h80 only -> grant=8'h80 continuously, owner_done every 4 cycles, valid never drops.
- Async reset mid-grant: rst_n pulsed low for 3 ns while owner=3 -> outputs clear immediately; after reset, req=8'h08 gives grant=8'h08 one edge later.
- Lock (MUX8_ARB_LOCK_EN defined): req=8'h03, lock=1 -> owner 0 holds for 10 cycles; lock=0 -> release within MAX_HOLD, then grant=8'h02.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Binary index of a one-hot vector; an all-zero input encodes to 0.
   function automatic logic [SEL_W-1:0] onehot_to_bin(input logic [NUM_REQ-1:0] onehot);
      logic [SEL_W-1:0] bin;
      bin = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (onehot[i]) bin = bin | SEL_W'(i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational cyclic priority picker: first set request at or after ptr, wrapping mod 8.
module rr_pick8
   import mux8_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   logic [2*NUM_REQ-1:0] w_req_dbl;
   logic [NUM_REQ-1:0]   w_req_rot;
   logic [SEL_W-1:0]     w_offset;

   // Rotating right by ptr puts requester ptr at bit 0, so a plain lowest-set search gives cyclic priority.
   assign w_req_dbl = {req, req} >> ptr;
   assign w_req_rot = w_req_dbl[NUM_REQ-1:0];

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_offset = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_req_rot[i]) w_offset = SEL_W'(i);
      end
   end

   assign found = |req;
   assign idx   = ptr + w_offset;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbiter driving the 8:1 mux select, with a bounded hold window per owner.
// Optional macro MUX8_ARB_LOCK_EN adds a lock input that suspends the hold-window limit.
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int HOLD_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
`ifdef MUX8_ARB_LOCK_EN
   input  logic               lock,
`endif
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   sel,
   output logic               valid,
   output logic               owner_done
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t             r_state,    w_state_nxt;
   logic [NUM_REQ-1:0] r_grant,    w_grant_nxt;
   logic [SEL_W-1:0]   r_sel,      w_sel_nxt;
   logic               r_valid,    w_valid_nxt;
   logic [SEL_W-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
   logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;

   logic               w_lock;
   logic               w_hold_last;
   logic               w_release;
   logic [SEL_W-1:0]   w_owner_next;
   logic [SEL_W-1:0]   w_pick_ptr;
   logic               w_found;
   logic [SEL_W-1:0]   w_idx;
   logic [NUM_REQ-1:0] w_win_onehot;

`ifdef MUX8_ARB_LOCK_EN
   assign w_lock = lock;
`else
   assign w_lock = 1'b0;
`endif

   assign w_hold_last  = (r_hold_cnt == HOLD_LAST);
   assign w_release    = (r_state == GRANT) && (!req[r_sel] || (w_hold_last && !w_lock));
   assign w_owner_next = r_sel + SEL_W'(1);

   // On release the scan starts just past the current owner, so it can only re-win when alone.
   assign w_pick_ptr   = (r_state == GRANT) ? w_owner_next : r_rr_ptr;

   rr_pick8 u_pick (
      .req   (req),
      .ptr   (w_pick_ptr),
      .found (w_found),
      .idx   (w_idx)
   );

   assign w_win_onehot = NUM_REQ'(1) << w_idx;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_sel      <= '0;
         r_valid    <= 1'b0;
         r_rr_ptr   <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_sel      <= w_sel_nxt;
         r_valid    <= w_valid_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_sel_nxt      = r_sel;
      w_valid_nxt    = r_valid;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_hold_cnt_nxt = r_hold_cnt;

      unique case (r_state)
         IDLE: begin
            w_hold_cnt_nxt = '0;
            if (w_found) begin
               w_state_nxt = GRANT;
               w_grant_nxt = w_win_onehot;
               w_sel_nxt   = onehot_to_bin(w_win_onehot);
               w_valid_nxt = 1'b1;
            end else begin
               w_grant_nxt = '0;
               w_sel_nxt   = '0;
               w_valid_nxt = 1'b0;
            end
         end

         GRANT: begin
            if (w_release) begin
               w_rr_ptr_nxt   = w_owner_next;
               w_hold_cnt_nxt = '0;
               if (w_found) begin
                  w_grant_nxt = w_win_onehot;
                  w_sel_nxt   = onehot_to_bin(w_win_onehot);
                  w_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_grant_nxt = '0;
                  w_sel_nxt   = '0;
                  w_valid_nxt = 1'b0;
               end
            end else if (!w_hold_last) begin
               // Saturates at the last hold value while a lock keeps the owner in place.
               w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      grant      = r_grant;
      sel        = r_sel;
      valid      = r_valid;
      owner_done = w_release;
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: default MAX_HOLD=4 instance plus a MAX_HOLD=1 instance.
module tb_mux8_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       lock;
   logic [7:0] grant,  grant1;
   logic [2:0] sel,    sel1;
   logic       valid,  valid1;
   logic       owner_done, owner_done1;

   int n_checks;
   int n_fail;

   mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
`ifdef MUX8_ARB_LOCK_EN
      .lock       (lock),
`endif
      .grant      (grant),
      .sel        (sel),
      .valid      (valid),
      .owner_done (owner_done)
   );

   mux8_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(8)) u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
`ifdef MUX8_ARB_LOCK_EN
      .lock       (lock),
`endif
      .grant      (grant1),
      .sel        (sel1),
      .valid      (valid1),
      .owner_done (owner_done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held across one falling edge; released there so the next rising edge is the first active one.
   task automatic apply_reset(input logic [7:0] req_v);
      req   = req_v;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int owner;
      n_checks = 0;
      n_fail   = 0;
      lock     = 1'b0;
      req      = 8'hFF;
      rst_n    = 1'b0;

      // Reset state with every requester asking
      #2;
      check("rst_grant", grant, 8'h00);
      check("rst_sel",   sel,   3'd0);
      check("rst_valid", valid, 1'b0);
      check("rst_done",  owner_done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full rotation, 4 cycles per owner; MAX_HOLD=1 instance rotates every cycle
      for (int k = 0; k < 33; k++) begin
         tick();
         owner = (k / 4) % 8;
         check("rot_grant", grant, 8'h01 << owner);
         check("rot_sel",   sel,   owner);
         check("rot_valid", valid, 1'b1);
         check("rot_done",  owner_done, (k % 4) == 3);
         check("h1_grant",  grant1, 8'h01 << (k % 8));
         check("h1_sel",    sel1,   k % 8);
         check("h1_done",   owner_done1, 1'b1);
      end

      // Early release: owner 2 drops after 2 cycles, requester 5 takes over back-to-back
      apply_reset(8'h24);
      tick();
      check("early_grant0", grant, 8'h04);
      check("early_sel0",   sel,   3'd2);
      check("early_done0",  owner_done, 1'b0);
      tick();
      check("early_grant1", grant, 8'h04);
      req = 8'h20;
      #1;
      check("early_done",   owner_done, 1'b1);
      tick();
      check("early_grant2", grant, 8'h20);
      check("early_sel2",   sel,   3'd5);
      check("early_valid2", valid, 1'b1);

      // Sole requester 7 re-wins each window without dropping valid
      apply_reset(8'h80);
      for (int k = 0; k < 12; k++) begin
         tick();
         check("sole_grant", grant, 8'h80);
         check("sole_sel",   sel,   3'd7);
         check("sole_valid", valid, 1'b1);
         check("sole_done",  owner_done, (k % 4) == 3);
      end

      // Asynchronous reset while owner 3 holds
      apply_reset(8'h08);
      tick();
      check("ar_grant0", grant, 8'h08);
      tick();
      check("ar_sel0",   sel,   3'd3);
      rst_n = 1'b0;
      #1;
      check("ar_grant_clr", grant, 8'h00);
      check("ar_sel_clr",   sel,   3'd0);
      check("ar_valid_clr", valid, 1'b0);
      check("ar_done_clr",  owner_done, 1'b0);
      #2;
      rst_n = 1'b1;
      tick();
      check("ar_grant1", grant, 8'h08);
      check("ar_sel1",   sel,   3'd3);

      // Release with no other requester returns to idle
      req = 8'h00;
      #1;
      check("idle_done",   owner_done, 1'b1);
      tick();
      check("idle_grant",  grant, 8'h00);
      check("idle_sel",    sel,   3'd0);
      check("idle_valid",  valid, 1'b0);
      check("idle_done2",  owner_done, 1'b0);

      // Pointer moved past owner 3: requesters 0 and 4 pending, 4 wins
      req = 8'h11;
      tick();
      check("ptr_grant", grant, 8'h10);
      check("ptr_sel",   sel,   3'd4);

`ifdef MUX8_ARB_LOCK_EN
      // Lock suppresses the hold limit; dropping it releases at once
      lock = 1'b1;
      apply_reset(8'h03);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("lock_grant", grant, 8'h01);
         check("lock_done",  owner_done, 1'b0);
      end
      lock = 1'b0;
      #1;
      check("unlock_done", owner_done, 1'b1);
      tick();
      check("unlock_grant", grant, 8'h02);
      check("unlock_sel",   sel,   3'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
